// File: rtl/fifo_pkg.sv
// Shared types for the FIFO controller: occupancy state encoding.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer: advances by one on inc, rolls over at 2**W.
module fifo_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Natural binary wrap gives the modulo-depth behaviour for free.
  always_ff @(posedge clk) begin
    if (reset)    ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy, status and sticky error flags for an
// external register file. Define FIFO_CTRL_WATERMARK_EN to enable the
// occupancy high-watermark register behind max_count; otherwise it reads 0.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH      = 2,
  parameter int ALMOST_FULL_TH  = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic                rd,
  input  logic                clr_err,
  output logic                wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_WIDTH:0] count,
  output logic                overflow,
  output logic                underflow,
  output logic [ADDR_WIDTH:0] max_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  fifo_state_e         state_q, state_d;
  logic                push, pop;
  logic [ADDR_WIDTH:0] count_nxt;

  // A push into a full FIFO is legal only when a pop frees the slot the same
  // cycle. Reset masks both so the register file sees no write during reset.
  assign push  = wr & (~full | rd) & ~reset;
  assign pop   = rd & ~empty & ~reset;
  assign wr_en = push;

  fifo_ptr #(.W(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wr_addr)
  );

  fifo_ptr #(.W(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .ptr   (rd_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next-state: only net occupancy changes move the state; simultaneous
  // push/pop holds it (including FULL, where both are accepted).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (push) state_d = PARTIAL;
      PARTIAL: begin
        if (push && !pop && count == DEPTH - ONE)  state_d = FULL;
        else if (pop && !push && count == ONE)     state_d = EMPTY;
      end
      FULL:    if (pop && !push) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    empty = (state_q == EMPTY);
    full  = (state_q == FULL);
  end

  // Occupancy next value; shared by the count register and the watermark.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + ONE;
    else if (pop && !push) count_nxt = count - ONE;
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  // Sticky error flags; a new error in the clearing cycle stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (rd && empty)       underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

`ifdef FIFO_CTRL_WATERMARK_EN
  // High watermark tracks the post-update occupancy; clr_err restarts it.
  always_ff @(posedge clk) begin
    if (reset || clr_err)       max_count <= '0;
    else if (count_nxt > max_count) max_count <= count_nxt;
  end
`else
  assign max_count = '0;
`endif

endmodule
